// File: rtl/alu_wide_seq_pkg.sv
// Shared ALU definitions: the 8-bit ALU control encoding, plus the wide-op and
// sequencer-state types used by the multi-byte sequencer.
package ALU_def;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_ADDC = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } ALU_CTRL;

    typedef enum logic [1:0] {
        WADD = 2'd0,
        WSUB = 2'd1,
        WAND = 2'd2,
        WOR  = 2'd3
    } wide_op_t;

    typedef enum logic [1:0] {
        WS_IDLE = 2'd0,
        WS_RUN  = 2'd1,
        WS_DONE = 2'd2
    } wide_state_t;

endpackage

// File: rtl/alu_wide_seq_alu.sv
// 8-bit combinational ALU driven one byte at a time by the wide sequencer.
// Carry-in is owned by the caller; cout is carry out of bit 7 (not-borrow for SUB).
module ALU
    import ALU_def::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [2:0] ctrl,
    output logic [7:0] y,
    output logic       cout,
    output logic       zero
);

    logic [8:0] sum;

    always_comb begin
        sum = 9'd0;
        case (ALU_CTRL'(ctrl))
            ALU_ADD:  sum = {1'b0, a} + {1'b0, b};
            ALU_ADDC: sum = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            ALU_SUB:  sum = {1'b0, a} + {1'b0, ~b} + 9'd1;
            ALU_AND:  sum = {1'b0, a & b};
            ALU_OR:   sum = {1'b0, a | b};
            ALU_XOR:  sum = {1'b0, a ^ b};
            default:  sum = {1'b0, a};
        endcase
    end

    assign y    = sum[7:0];
    assign cout = sum[8];
    assign zero = (sum[7:0] == 8'd0);

endmodule

// File: rtl/alu_wide_seq.sv
// Multi-byte sequencer: streams wide operands through the 8-bit ALU LSB first,
// chaining carry between bytes, and publishes result/carry/zero once per op.
module alu_wide_seq
    import ALU_def::*;
#(
    parameter int NBYTES = 4,
    localparam int W     = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         zero_out
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    wide_state_t state_q, state_d;
    wide_op_t    op_q;

    logic [NBYTES-1:0][7:0] a_q, b_q, shadow_q, shadow_d;
    logic [IDX_W-1:0]       idx_q;
    logic                   carry_q;
    logic                   zacc_q;
    logic [W-1:0]           result_q;
    logic                   carry_out_q;
    logic                   zero_out_q;

    logic       accept;
    logic       last_byte;
    logic       logic_op;
    logic [7:0] alu_a, alu_b, alu_y;
    logic       alu_cout, alu_zero;
    logic       carry_nxt;
    ALU_CTRL    alu_ctrl;

    assign accept    = (state_q == WS_IDLE) && start;
    assign last_byte = (idx_q == LAST_IDX);
    assign logic_op  = (op_q == WAND) || (op_q == WOR);

    // Byte select; subtraction is a + ~b + 1 with the +1 preloaded into the carry reg
    assign alu_a = a_q[idx_q];
    assign alu_b = (op_q == WSUB) ? ~b_q[idx_q] : b_q[idx_q];

    always_comb begin
        alu_ctrl = ALU_ADDC;
        case (op_q)
            WADD:    alu_ctrl = (idx_q == '0) ? ALU_ADD : ALU_ADDC;
            WSUB:    alu_ctrl = ALU_ADDC;
            WAND:    alu_ctrl = ALU_AND;
            WOR:     alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_ADDC;
        endcase
    end

    ALU u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .cin  (carry_q),
        .ctrl (alu_ctrl),
        .y    (alu_y),
        .cout (alu_cout),
        .zero (alu_zero)
    );

    assign carry_nxt = logic_op ? 1'b0 : alu_cout;

    // Final byte is merged here so result can be published on the same edge
    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[idx_q] = alu_y;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WS_IDLE: if (start) state_d = WS_RUN;
            WS_RUN:  if (last_byte) state_d = WS_DONE;
            WS_DONE: state_d = WS_IDLE;
            default: state_d = WS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= WS_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            zacc_q      <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_out_q  <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            carry_q <= (wide_op_t'(op) == WSUB);
            zacc_q  <= 1'b1;
        end else if (state_q == WS_RUN) begin
            carry_q <= carry_nxt;
            zacc_q  <= zacc_q & alu_zero;
            if (last_byte) begin
                result_q    <= shadow_d;
                carry_out_q <= carry_nxt;
                zero_out_q  <= zacc_q & alu_zero;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Operand and shadow storage is pure data, qualified by accept/RUN only
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            a_q  <= a_in;
            b_q  <= b_in;
            op_q <= wide_op_t'(op);
        end
        if (state_q == WS_RUN) shadow_q <= shadow_d;
    end

    assign busy      = (state_q == WS_RUN);
    assign done      = (state_q == WS_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero_out  = zero_out_q;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Randomized and directed bench for alu_wide_seq against a plain-arithmetic wide model.
module tb_alu_wide_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, carry_out, zero_out;
    logic [W-1:0] result;

    int n_chk = 0;
    int n_err = 0;

    alu_wide_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero_out  (zero_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic c, output logic z);
        logic [32:0] s;
        case (o)
            2'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            2'd1: begin r = a - b; c = (a >= b); end
            2'd2: begin r = a & b; c = 1'b0; end
            default: begin r = a | b; c = 1'b0; end
        endcase
        z = (r == 32'd0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit spam, input string tag);
        logic [31:0] er;
        logic        ec, ez;
        bit          seen;
        ref_op(o, a, b, er, ec, ez);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(posedge clk);
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                chk({tag, " latency"}, 32'(k), 32'(NB + 1));
                chk({tag, " result"}, result, er);
                chk({tag, " carry"}, 32'(carry_out), 32'(ec));
                chk({tag, " zero"}, 32'(zero_out), 32'(ez));
                chk({tag, " busy@done"}, 32'(busy), 32'd0);
            end else begin
                chk({tag, " busy"}, 32'(busy), 32'd1);
            end
            if (spam) begin
                start = 1'b1; op = 2'($urandom); a_in = $urandom; b_in = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        if (!seen) chk({tag, " timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " single pulse"}, 32'(done), 32'd0);
        chk({tag, " idle"}, 32'(busy), 32'd0);
        chk({tag, " held"}, result, er);
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1;
            3:       return 32'h0000_00FF << (8 * $urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'd0; a_in = '0; b_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst carry", 32'(carry_out), 32'd0);
        chk("rst zero", 32'(zero_out), 32'd0);
        reset = 1'b0;

        run_op(2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0, "add ff+1");
        run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "add wrap");
        run_op(2'd1, 32'h0000_0100, 32'h0000_0001, 1'b0, "sub 100-1");
        run_op(2'd1, 32'h0000_0000, 32'h0000_0001, 1'b0, "sub 0-1");
        run_op(2'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, "and");
        run_op(2'd3, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, "or");
        run_op(2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b1, "add spam");

        // Abort on the second RUN cycle
        @(negedge clk);
        start = 1'b1; op = 2'd0; a_in = 32'h1234_5678; b_in = 32'h1111_1111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort carry", 32'(carry_out), 32'd0);
        chk("abort zero", 32'(zero_out), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("abort no done", 32'(done | busy), 32'd0);
        end
        run_op(2'd0, 32'd1, 32'd1, 1'b0, "add 1+1");

        // Reset and start together: start dropped
        @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 2'd3; a_in = 32'hFFFF_FFFF; b_in = 32'd0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst+start busy", 32'(busy), 32'd0);
        chk("rst+start result", result, 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("rst+start no done", 32'(done), 32'd0);
        end

        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom), pick_val(), pick_val(), bit'($urandom_range(0, 1)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
